div_seq: RTL and testbench

//  Sequential restoring divider: the inverse of the combinational multiplier.

---
 rtl/div_seq.sv | 127 ++++++++++++
 tb/tb_div_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define DIV_SIGNED_EN for two's-complement operands (sign fix-up around the unsigned core).
module div_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] div_i1,
    input  logic [WIDTH-1:0] div_i2,
    input  logic             div_valid_i,
    output logic             div_ready_o,
    output logic [WIDTH-1:0] div_o,
    output logic [WIDTH-1:0] div_rem_o,
    output logic             div_dbz_o,
    output logic             div_valid_o,
    input  logic             div_ready_i
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    cnt;
    logic             dbz;

    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
`endif

    // rem_sh holds the guard bit so the compare cannot overflow; the
    // subtracted result is always < dsr and fits back in WIDTH bits.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        ge     = rem_sh >= {1'b0, dsr};
        rem_nx = ge ? (rem_sh[WIDTH-1:0] - dsr) : rem_sh[WIDTH-1:0];
        quo_nx = {quo[WIDTH-2:0], ge};
`ifdef DIV_SIGNED_EN
        a_in  = div_i1[WIDTH-1] ? -div_i1 : div_i1;
        b_in  = div_i2[WIDTH-1] ? -div_i2 : div_i2;
        q_fin = neg_q ? -quo_nx : quo_nx;
        r_fin = neg_r ? -rem_nx : rem_nx;
`else
        a_in  = div_i1;
        b_in  = div_i2;
        q_fin = quo_nx;
        r_fin = rem_nx;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem         <= '0;
            quo         <= '0;
            dsr         <= '0;
            cnt         <= '0;
            dbz         <= 1'b0;
            div_ready_o <= 1'b1;
            div_valid_o <= 1'b0;
            div_o       <= '0;
            div_rem_o   <= '0;
            div_dbz_o   <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (div_valid_i && div_ready_o) begin
                        state       <= CALC;
                        div_ready_o <= 1'b0;
                        rem         <= '0;
                        dsr         <= b_in;
`ifdef DIV_SIGNED_EN
                        neg_q       <= div_i1[WIDTH-1] ^ div_i2[WIDTH-1];
                        neg_r       <= div_i1[WIDTH-1];
`endif
                        // Divide-by-zero spends one CALC cycle with the raw dividend parked in quo.
                        if (div_i2 == '0) begin
                            dbz <= 1'b1;
                            quo <= div_i1;
                            cnt <= CW'(1);
                        end else begin
                            dbz <= 1'b0;
                            quo <= a_in;
                            cnt <= CW'(WIDTH);
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= DONE;
                        div_valid_o <= 1'b1;
                        div_o       <= dbz ? '1  : q_fin;
                        div_rem_o   <= dbz ? quo : r_fin;
                        div_dbz_o   <= dbz;
                    end
                end
                DONE: begin
                    if (div_ready_i) begin
                        state       <= IDLE;
                        div_valid_o <= 1'b0;
                        div_ready_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq at WIDTH=16: latency, backpressure, divide-by-zero, reset mid-CALC.
module tb_div_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] div_i1 = '0;
    logic [W-1:0] div_i2 = '0;
    logic         div_valid_i = 1'b0;
    logic         div_ready_o;
    logic [W-1:0] div_o;
    logic [W-1:0] div_rem_o;
    logic         div_dbz_o;
    logic         div_valid_o;
    logic         div_ready_i = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q_exp[$];
    logic [W-1:0] r_exp[$];
    logic         d_exp[$];
    int           l_exp[$];

    div_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .div_i1(div_i1), .div_i2(div_i2), .div_valid_i(div_valid_i), .div_ready_o(div_ready_o),
        .div_o(div_o), .div_rem_o(div_rem_o), .div_dbz_o(div_dbz_o),
        .div_valid_o(div_valid_o), .div_ready_i(div_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: pushes expected quotient/remainder/dbz and latency.
    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
`ifdef DIV_SIGNED_EN
        logic signed [W-1:0] sa, sb;
        sa = a; sb = b;
        if (b == 0) begin q = '1; r = a; end
        else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin q = a; r = '0; end
        else begin q = sa / sb; r = sa % sb; end
`else
        if (b == 0) begin q = '1; r = a; end
        else begin q = a / b; r = a % b; end
`endif
        q_exp.push_back(q);
        r_exp.push_back(r);
        d_exp.push_back(b == 0);
        l_exp.push_back((b == 0) ? 1 : W);
    endtask

    // Drive one operation; hold off the result for k cycles of backpressure.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        int n;
        n = 0;
        while (!div_ready_o && n < 100) begin @(negedge clk); n++; end
        chk("ready_before", div_ready_o, 1);
        div_i1 = a; div_i2 = b; div_valid_i = 1'b1;
        div_ready_i = (k == 0);
        push_exp(a, b);
        @(negedge clk);
        div_valid_i = 1'b0;
        n = 0;
        while (!div_valid_o && n < 100) begin
            if (div_ready_o) chk("busy_ready", div_ready_o, 0);
            // Junk operands during CALC must be ignored.
            div_valid_i = n[0];
            div_i1 = W'($urandom);
            div_i2 = W'($urandom);
            @(negedge clk);
            n++;
        end
        div_valid_i = 1'b0;
        chk("latency", n, l_exp.pop_front());
        for (int i = 0; i < k; i++) begin
            chk("hold_valid", div_valid_o, 1);
            chk("hold_q", div_o, q_exp[0]);
            chk("hold_r", div_rem_o, r_exp[0]);
            chk("hold_ready", div_ready_o, 0);
            div_valid_i = 1'b1;
            @(negedge clk);
        end
        div_valid_i = 1'b0;
        div_ready_i = 1'b1;
        chk("valid", div_valid_o, 1);
        chk("quo", div_o, q_exp.pop_front());
        chk("rem", div_rem_o, r_exp.pop_front());
        chk("dbz", div_dbz_o, d_exp.pop_front());
        @(negedge clk);
        div_ready_i = 1'b0;
        chk("valid_drop", div_valid_o, 0);
        chk("ready_back", div_ready_o, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", div_ready_o, 1);
        chk("rst_valid", div_valid_o, 0);
        chk("rst_q", div_o, 0);
        chk("rst_r", div_rem_o, 0);
        chk("rst_dbz", div_dbz_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_div(16'd1000, 16'd7, 0);
        do_div(16'h1234, 16'h0000, 0);
        do_div(16'hFFFF, 16'h0001, 5);
        do_div(16'hFFFF, 16'hFFFF, 0);
        do_div(16'h0005, 16'h0009, 2);
        do_div(16'h0000, 16'h0003, 0);
        do_div(16'h8000, 16'h0002, 1);

        // Reset mid-CALC: pending result is discarded.
        div_i1 = 16'd500; div_i2 = 16'd3; div_valid_i = 1'b1;
        @(negedge clk);
        div_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", div_ready_o, 1);
        chk("mid_rst_valid", div_valid_o, 0);
        chk("mid_rst_q", div_o, 0);
        chk("mid_rst_r", div_rem_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_div(16'd9, 16'd3, 0);

`ifdef DIV_SIGNED_EN
        do_div(16'hFFF9, 16'h0002, 0);
        do_div(16'h0007, 16'hFFFE, 0);
        do_div(16'h8000, 16'hFFFF, 0);
        do_div(16'hFF00, 16'h0000, 0);
`endif

        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = (i % 4 == 0) ? W'(0) : W'($urandom_range(1, (i % 2) ? 20 : 65535));
            do_div(a, b, i % 3);
        end

        repeat (5) begin
            @(negedge clk);
            chk("no_extra", div_valid_o, 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
